// File: rtl/conv_image_loader.sv
// Streaming pixel loader: assembles valid/ready beats into a flat big-endian
// image vector and holds it (conv layer out of reset) until the frame is acked.
module conv_image_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int D          = 1,
  parameter int H          = 32,
  parameter int W          = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [DATA_WIDTH-1:0]              s_data,
  input  logic                               s_last,
  output logic [0:D*H*W*DATA_WIDTH-1]        image,
  output logic                               conv_reset,
  output logic                               frame_valid,
  input  logic                               frame_ack,
  output logic                               frame_err,
  output logic                               dbg_state_o
);

  localparam int N  = D * H * W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  // Handshake: a beat transfers on a rising edge where s_valid && s_ready;
  // upstream must hold s_data/s_last stable while s_valid is high and s_ready low.

  typedef enum logic {
    LOAD = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic [CW-1:0]               count_q, count_d;
  logic                        frame_err_q, frame_err_d;
  logic [0:N*DATA_WIDTH-1]     image_q;
  logic                        accept;

  assign accept = (state_q == LOAD) && s_valid;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    frame_err_d = 1'b0;
    case (state_q)
      LOAD: begin
        if (accept) begin
          if (count_q == LAST_IDX) begin
            // Full frame completes even without s_last; missing marker is flagged.
            state_d     = HOLD;
            count_d     = '0;
            frame_err_d = ~s_last;
          end else if (s_last) begin
            count_d     = '0;
            frame_err_d = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (frame_ack) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= LOAD;
      count_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Element n lives at the n-th slice from the most significant end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      image_q <= '0;
    end else if (accept) begin
      image_q[count_q*DATA_WIDTH +: DATA_WIDTH] <= s_data;
    end
  end

  assign image       = image_q;
  assign s_ready     = (state_q == LOAD);
  assign conv_reset  = (state_q == LOAD);
  assign frame_valid = (state_q == HOLD);
  assign frame_err   = frame_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_conv_image_loader.sv
// Directed bench for conv_image_loader on a 1x4x4 frame with a pixel scoreboard.
module tb_conv_image_loader;

  localparam int DW = 16;
  localparam int D  = 1;
  localparam int H  = 4;
  localparam int W  = 4;
  localparam int N  = D * H * W;

  logic              clk;
  logic              reset;
  logic              s_valid;
  logic              s_ready;
  logic [DW-1:0]     s_data;
  logic              s_last;
  logic [0:N*DW-1]   image;
  logic              conv_reset;
  logic              frame_valid;
  logic              frame_ack;
  logic              frame_err;
  logic              dbg_state_o;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_frame[N];
  int checks = 0;
  int errors = 0;

  conv_image_loader #(.DATA_WIDTH(DW), .D(D), .H(H), .W(W)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .image(image), .conv_reset(conv_reset),
    .frame_valid(frame_valid), .frame_ack(frame_ack), .frame_err(frame_err),
    .dbg_state_o(dbg_state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one beat, waits for acceptance, checks frame_err/frame_valid after the edge.
  task automatic send_beat(input string tag, input logic [DW-1:0] d, input logic l,
                           input logic exp_err, input logic exp_fv);
    int guard;
    guard   = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && guard < 50) begin
      tick();
      guard++;
    end
    check({tag, "_ready_wait"}, 64'(guard < 50), 64'd1);
    tick();
    exp_q.push_back(d);
    s_valid = 1'b0;
    s_last  = 1'b0;
    check({tag, "_err"}, 64'(frame_err), 64'(exp_err));
    check({tag, "_fv"}, 64'(frame_valid), 64'(exp_fv));
  endtask

  task automatic check_frame(input string tag);
    logic [DW-1:0] e;
    check({tag, "_fv"}, 64'(frame_valid), 64'd1);
    check({tag, "_crst"}, 64'(conv_reset), 64'd0);
    check({tag, "_rdy"}, 64'(s_ready), 64'd0);
    check({tag, "_state"}, 64'(dbg_state_o), 64'd1);
    check({tag, "_qsize"}, 64'(exp_q.size()), 64'(N));
    for (int n = 0; n < N; n++) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 16'hDEAD;
      last_frame[n] = e;
      check($sformatf("%s_px%0d", tag, n), 64'(image[n*DW +: DW]), 64'(e));
    end
  endtask

  task automatic ack_frame(input string tag);
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    check({tag, "_fv"}, 64'(frame_valid), 64'd0);
    check({tag, "_crst"}, 64'(conv_reset), 64'd1);
    check({tag, "_rdy"}, 64'(s_ready), 64'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rdy"}, 64'(s_ready), 64'd1);
    check({tag, "_crst"}, 64'(conv_reset), 64'd1);
    check({tag, "_fv"}, 64'(frame_valid), 64'd0);
    check({tag, "_err"}, 64'(frame_err), 64'd0);
    check({tag, "_img"}, 64'(|image), 64'd0);
  endtask

  initial begin
    logic [DW-1:0] v;
    reset     = 1'b1;
    s_valid   = 1'b0;
    s_data    = '0;
    s_last    = 1'b0;
    frame_ack = 1'b0;
    repeat (2) tick();
    check_reset_vals("rst");
    reset = 1'b0;
    tick();

    // Continuous stream, data = n+1
    for (int n = 0; n < N; n++)
      send_beat($sformatf("t1_b%0d", n), DW'(n + 1), n == N - 1, 1'b0, n == N - 1);
    check_frame("t1");
    ack_frame("t1_ack");

    // s_valid toggling with an idle cycle between beats
    for (int n = 0; n < N; n++) begin
      send_beat($sformatf("t2_b%0d", n), DW'(n + 1), n == N - 1, 1'b0, n == N - 1);
      if (n != N - 1) begin
        tick();
        check($sformatf("t2_idle_rdy%0d", n), 64'(s_ready), 64'd1);
      end
    end
    check_frame("t2");

    // Upstream pushes garbage during HOLD; image must stay frozen
    s_valid = 1'b1;
    s_data  = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("t3_hold_rdy%0d", i), 64'(s_ready), 64'd0);
    end
    for (int n = 0; n < N; n++)
      check($sformatf("t3_frozen_px%0d", n), 64'(image[n*DW +: DW]), 64'(last_frame[n]));
    s_valid = 1'b0;
    ack_frame("t3_ack");

    // Short frame: s_last on beat 5
    for (int n = 0; n < 5; n++)
      send_beat($sformatf("t4s_b%0d", n), DW'(16'h0A0 + n), n == 4, n == 4, 1'b0);
    exp_q.delete();
    tick();
    check("t4_err_one_cycle", 64'(frame_err), 64'd0);
    check("t4_state_load", 64'(dbg_state_o), 64'd0);
    for (int n = 0; n < N; n++)
      send_beat($sformatf("t4_b%0d", n), DW'(16'h100 + n), n == N - 1, 1'b0, n == N - 1);
    check_frame("t4");
    ack_frame("t4_ack");

    // Full frame with no s_last: error flagged on the last beat, frame still held
    for (int n = 0; n < N; n++)
      send_beat($sformatf("t5_b%0d", n), DW'(16'h200 + n), 1'b0, n == N - 1, n == N - 1);
    tick();
    check("t5_err_one_cycle", 64'(frame_err), 64'd0);
    check_frame("t5");

    // Asynchronous reset while holding: conv_reset must rise without a clock edge
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_vals("t5_rst_hold");
    tick();
    reset = 1'b0;

    // Reset mid-frame after 8 beats, then a fresh random frame
    for (int n = 0; n < 8; n++)
      send_beat($sformatf("t6p_b%0d", n), DW'($urandom_range(0, 16'hFFFF)), 1'b0, 1'b0, 1'b0);
    exp_q.delete();
    reset = 1'b1;
    #1;
    check_reset_vals("t6_rst");
    tick();
    reset = 1'b0;
    tick();
    for (int n = 0; n < N; n++) begin
      v = DW'($urandom_range(0, 16'hFFFF));
      send_beat($sformatf("t6_b%0d", n), v, n == N - 1, 1'b0, n == N - 1);
    end
    check_frame("t6");
    ack_frame("t6_ack");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/conv_image_loader.md
# conv_image_loader

Streaming front end for the convolution datapath. Accepts pixels one per beat over a valid/ready handshake and assembles them into the flat, big-endian-indexed image vector the convolution layers read. When a full frame is held, it releases the conv layer's reset and presents the frame stable until the downstream control acknowledges completion. It is the writer side of the flat image bus: one loader per conv layer input.

## Interface
- DATA_WIDTH, 16, bits per pixel (signed fixed-point, passed through untouched)
- D, 1, image depth (channels)
- H, 32, image height
- W, 32, image width
- N = D*H*W (derived, not overridable), pixels per frame
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- s_valid  in  1  upstream pixel valid
- s_ready  out  1  loader can accept a pixel
- s_data  in  DATA_WIDTH  pixel value
- s_last  in  1  marks final pixel of frame
- image  out  [0:N*DATA_WIDTH-1]  assembled frame, registered
- conv_reset  out  1  reset to the conv layer; high while loading
- frame_valid  out  1  complete frame held on image
- frame_ack  in  1  downstream finished with frame
- frame_err  out  1  one-cycle pulse on framing error

## Operation
- Pixel order: channel-major, then row, then column. Element n = (d*H + r)*W + c, stored at image[n*DATA_WIDTH +: DATA_WIDTH], so element 0 occupies the lowest-index (most significant) slice.
- Beat accepted on a rising edge where s_valid && s_ready. Nothing else writes image.
- Pixel counter: clog2(N) bits, 0..N-1, no wrap beyond N-1.
- FSM, two states:
  - LOAD: s_ready=1, conv_reset=1, frame_valid=0. Each accepted beat writes slice[count] and increments count.
    - Beat with count==N-1: go HOLD, count to 0. If s_last=0 on this beat, pulse frame_err; frame still completes.
    - Beat with s_last=1 and count<N-1: pixel is written, pulse frame_err, count to 0, stay LOAD (short frame discarded; next beat is element 0).
  - HOLD: s_ready=0, conv_reset=0, frame_valid=1, image frozen. frame_ack=1: go LOAD. s_valid/s_data ignored.
- frame_ack ignored in LOAD.
- Out-of-range: none; counter reset guarantees count<N.

## Timing
- Reset values (asynchronous): state LOAD, count 0, image all zeros, s_ready 1, conv_reset 1, frame_valid 0, frame_err 0.
- All outputs registered; s_ready, conv_reset, frame_valid are decoded from the registered state.
- Final beat accepted at edge k: frame_valid=1, conv_reset=0, s_ready=0 from edge k onward (visible in the cycle after the handshake cycle); latency 1 cycle.
- frame_ack sampled high at edge j in HOLD: from edge j, frame_valid=0, conv_reset=1, s_ready=1. image keeps old contents until overwritten slice by slice.
- Minimum frame period: N accept cycles + 1 HOLD cycle (ack held high in the first HOLD cycle).
- frame_err: high exactly one cycle, beginning at the edge of the offending beat.
- Reset mid-frame: partial frame dropped, counter 0, image zeroed; asserting reset in HOLD forces conv_reset=1 immediately (asynchronous).
- s_valid may be held high continuously; a beat presented while s_ready=0 is not consumed and must be held by upstream.

## Test plan
- D=1,H=4,W=4: stream 16 beats, data = n+1, s_last on 16th, s_valid continuous -> frame_valid rises 1 cycle after beat 16, image slice n = n+1, frame_err never pulses, conv_reset falls with frame_valid.
- Same with s_valid toggling 1,0 every cycle -> identical image; s_ready stays 1 until final beat accepted.
- In HOLD, drive s_valid=1, data=0xFFFF for 10 cycles, then frame_ack one cycle -> image unchanged, s_ready=0 throughout HOLD, returns to LOAD next cycle with conv_reset=1.
- s_last on beat 5 -> frame_err one-cycle pulse, state LOAD; next 16 beats (data 0x100+n) form a valid frame with slice n = 0x100+n.
- 16 beats with s_last never asserted -> frame_err pulse on beat 16 and frame_valid still rises.
- Assert reset after beat 8 -> all outputs return to reset values asynchronously; a fresh 16-beat frame loads correctly from element 0.
